async_fifo_rd_packer: RTL
=========================

# async_fifo_rd_packer

Read-side consumer of the distributed-RAM async FIFO, living in the FIFO read clock domain. It pops narrow words through the FIFO's empty/rd_en port and packs RATIO consecutive words into one wide word, lowest lane first. It presents the packed word on a registered valid/ready output with per-lane byte enables. A flush input emits a partially filled word at frame ends.

## Interface
Parameters:
- IN_WIDTH, 8, FIFO data width; must equal the FIFO_WIDTH of the feeding FIFO.
- RATIO, 4, input words per output word; legal values 2, 4, 8.
- OUT_WIDTH, IN_WIDTH*RATIO, derived; not to be overridden.

Ports:
- clk  input  1  clock (FIFO read clock).
- reset_async  input  1  reset, asynchronous, active-high.
- i_fifo_empty  input  1  FIFO empty flag.
- o_fifo_rd_en  output  1  FIFO read strobe.
- iv_fifo_dout  input  IN_WIDTH  FIFO read data, valid in the cycle after the o_fifo_rd_en cycle.
- i_flush  input  1  single-cycle request to emit the partial word.
- o_valid  output  1  packed word valid.
- i_ready  input  1  downstream accepts.
- ov_dout  output  OUT_WIDTH  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
- ov_byte_en  output  RATIO  lane k holds valid data.

## Operation
Internal state:
- Accumulator, lanes 0..RATIO-2 plus a final-lane holding register.
- cnt, 0..RATIO: number of lanes filled.
- pending: a read was issued last cycle.
- flush_pend flag.
- Output register: o_valid, ov_dout, ov_byte_en.

Reads:
- o_fifo_rd_en = !i_fifo_empty && !flush_pend && (cnt + pending < RATIO). Combinational; forced 0 while reset is asserted.
- No other gating. The block never reads an empty FIFO.

Capture:
- When pending=1, iv_fifo_dout is written into lane cnt and cnt increments.
- If the captured word fills lane RATIO-1 and the output is free (!o_valid || i_ready), then {word, lanes 0..RATIO-2} loads the output register directly, ov_byte_en becomes all ones, and cnt returns to 0.
- If the output is not free, cnt=RATIO holds. The complete accumulator loads the output on the first edge where the output is free, then cnt returns to 0. o_valid stays 1 across a consume-and-reload edge.

Output:
- o_valid, once set, stays high and ov_dout/ov_byte_en stay stable until i_ready=1.
- On an edge with o_valid && i_ready and no reload, o_valid clears.

Flush:
- i_flush=1 sets flush_pend; reads are blocked while flush_pend=1.
- Once pending=0:
  - cnt=0: clear flush_pend; no word is emitted.
  - 0<cnt<RATIO and output free: load the partial word. Lanes >= cnt are zero. ov_byte_en = (1<<cnt)-1. cnt returns to 0 and flush_pend clears.
  - cnt=RATIO: normal full-word reload first, then clear flush_pend.
- i_flush while flush_pend=1 has no additional effect.

Reset:
- Asynchronous, from any state: cnt=0, pending=0, flush_pend=0, o_valid=0, ov_dout=0, ov_byte_en=0.
- A word in flight at reset is discarded.

## Timing
Latency:
- FIFO non-empty from cycle 0 with output free: reads in cycles 0..RATIO-1.
- Lane k is captured at the end of cycle k+1.
- o_valid is high from cycle RATIO+1.

Throughput:
- One bubble per packed word: reads are blocked in the cycle in which cnt+pending=RATIO.
- Sustained rate is RATIO input words per RATIO+1 clocks, with i_ready held high.

Backpressure:
- With o_valid=1 and i_ready=0, reads continue until cnt+pending=RATIO, then stop.
- At most RATIO words are buffered beyond the output register.

FIFO empty mid-word:
- Lanes already filled are held indefinitely; no timeout exists.
- Reads resume the cycle i_fifo_empty deasserts.

Flush completes:
- Cycle after i_flush with pending=0 and output free: the partial word is loaded at the end of that cycle.
- With a read in flight: one cycle later.

## Test plan
- RATIO=4, FIFO pre-loaded 0x11,0x22,0x33,0x44,0x55..0x88, i_ready=1 → ov_dout=0x44332211 with o_valid high in cycle 5. Then 0x88776655, with exactly one cycle between the 4th and 5th o_fifo_rd_en.
- Same data, i_ready=0 for 20 cycles → exactly 8 o_fifo_rd_en pulses, first word held stable. After i_ready=1, both words are delivered in back-to-back cycles.
- 3 words 0xA1,0xA2,0xA3 then i_flush → ov_dout=0x00A3A2A1, ov_byte_en=0b0111. No further reads occur until the flush completes.
- i_flush with cnt=0 and FIFO empty → o_valid stays 0 and flush_pend clears after one cycle.
- i_flush in the cycle the 4th word is read → full word 0x44332211 with ov_byte_en=0xF. No extra empty word follows.
- reset_async asserted mid-word (cnt=2, pending=1) → all outputs 0 immediately. After release, the next word packs from lane 0.

Source files
------------

// File: rtl/async_fifo_rd_packer.sv
// async_fifo_rd_packer: pops narrow FIFO words and packs RATIO of them into one wide valid/ready word.
module async_fifo_rd_packer #(
  parameter int IN_WIDTH  = 8,
  parameter int RATIO     = 4,
  parameter int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 reset_async,
  input  logic                 i_fifo_empty,
  output logic                 o_fifo_rd_en,
  input  logic [IN_WIDTH-1:0]  iv_fifo_dout,
  input  logic                 i_flush,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [OUT_WIDTH-1:0] ov_dout,
  output logic [RATIO-1:0]     ov_byte_en
);
  localparam int CW = $clog2(RATIO + 1);
  localparam int LW = $clog2(RATIO);
  logic [RATIO-1:0][IN_WIDTH-1:0] acc_q, acc_d, part;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pending_q, pending_d, flush_pend_q, flush_pend_d, valid_q, valid_d;
  logic [OUT_WIDTH-1:0] dout_q, dout_d;
  logic [RATIO-1:0] be_q, be_d, be_part;
  logic out_free, full;
  always_comb begin
    out_free = !valid_q || i_ready;
    o_fifo_rd_en = !reset_async && !i_fifo_empty && !flush_pend_q && (cnt_q + CW'(pending_q) < CW'(RATIO));
    pending_d = o_fifo_rd_en;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (pending_q) begin
      acc_d[cnt_q[LW-1:0]] = iv_fifo_dout;
      cnt_d = cnt_q + CW'(1);
    end
    for (int k = 0; k < RATIO; k++) begin
      part[k] = (k < int'(cnt_q)) ? acc_q[k] : '0;
      be_part[k] = k < int'(cnt_q);
    end
    full = cnt_d == CW'(RATIO);
    valid_d = valid_q && !i_ready;
    dout_d = dout_q;
    be_d = be_q;
    if (full && out_free) begin
      valid_d = 1'b1;
      dout_d = acc_d;
      be_d = '1;
      cnt_d = '0;
    end else if (flush_pend_q && !pending_q && cnt_q != '0 && out_free) begin
      valid_d = 1'b1;
      dout_d = part;
      be_d = be_part;
      cnt_d = '0;
    end
    // a pending flush retires once no read is in flight and any held word has been handed off
    flush_pend_d = flush_pend_q ? (pending_q || (cnt_q != '0 && !out_free)) : i_flush;
  end
  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      acc_q <= '0;
      cnt_q <= '0;
      pending_q <= 1'b0;
      flush_pend_q <= 1'b0;
      valid_q <= 1'b0;
      dout_q <= '0;
      be_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      pending_q <= pending_d;
      flush_pend_q <= flush_pend_d;
      valid_q <= valid_d;
      dout_q <= dout_d;
      be_q <= be_d;
    end
  end
  assign o_valid = valid_q;
  assign ov_dout = dout_q;
  assign ov_byte_en = be_q;
endmodule
